// File: rtl/data_mem_responder.sv
// Data-memory responder: a word array that clears itself after reset, takes
// writes in one cycle and returns reads through a READ_LATENCY-deep valid pipeline.
// READ_LATENCY must lie in 1..4 and MEM_SIZE must be a power of two, at least 2.
module data_mem_responder #(
    parameter int MEM_WIDTH    = 32,
    parameter int MEM_SIZE     = 256,
    parameter int READ_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(MEM_SIZE)-1:0] mem_addr,
    input  logic                        mem_read_en,
    input  logic                        mem_write_en,
    input  logic [MEM_WIDTH-1:0]        mem_write_val,
    output logic [MEM_WIDTH-1:0]        mem_read_val,
    output logic                        mem_read_valid,
    output logic                        mem_busy,
    output logic                        mem_conflict
);

    localparam int AW = $clog2(MEM_SIZE);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         clear_ptr_q, clear_ptr_d;
    logic                  conflict_q, conflict_d;
    logic                  rd_accept;

    logic                  arr_we;
    logic [AW-1:0]         arr_waddr;
    logic [MEM_WIDTH-1:0]  arr_wdata;
    logic [MEM_WIDTH-1:0]  mem_q [MEM_SIZE];

    logic [READ_LATENCY-1:0] rd_vld_q;
    logic [MEM_WIDTH-1:0]    rd_data_q [READ_LATENCY];

    // The array has a single write port, shared by the clear walk and user writes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        conflict_d  = 1'b0;
        rd_accept   = 1'b0;
        arr_we      = 1'b0;
        arr_waddr   = clear_ptr_q;
        arr_wdata   = '0;
        case (state_q)
            ST_CLEAR: begin
                arr_we      = 1'b1;
                clear_ptr_d = clear_ptr_q + AW'(1);
                if (clear_ptr_q == AW'(MEM_SIZE - 1)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                arr_we     = mem_write_en;
                arr_waddr  = mem_addr;
                arr_wdata  = mem_write_val;
                rd_accept  = mem_read_en & ~mem_write_en;
                conflict_d = mem_read_en & mem_write_en;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q     <= ST_CLEAR;
            clear_ptr_q <= '0;
            conflict_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            conflict_q  <= conflict_d;
        end
    end

    // NOTE: the array has no reset term; it is zeroed by the post-reset clear walk instead.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem_q[arr_waddr] <= arr_wdata;
        end
    end

    // Stage 0 samples the array at the request edge; later stages load only behind a valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                rd_data_q[i] <= '0;
            end
        end else begin
            rd_vld_q[0] <= rd_accept;
            if (rd_accept) begin
                rd_data_q[0] <= mem_q[mem_addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_vld_q[i] <= rd_vld_q[i-1];
                if (rd_vld_q[i-1]) begin
                    rd_data_q[i] <= rd_data_q[i-1];
                end
            end
        end
    end

    assign mem_read_val   = rd_data_q[READ_LATENCY-1];
    assign mem_read_valid = rd_vld_q[READ_LATENCY-1];
    assign mem_busy       = (state_q == ST_CLEAR);
    assign mem_conflict   = conflict_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three responders (READ_LATENCY 1, 2, 3) share one stimulus
// stream; read pulses are logged per instance and compared with hand-computed values.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic [7:0]  addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rd_val [1:3];
    logic [3:1]  rd_valid;
    logic [3:1]  busy;
    logic [3:1]  conflict;

    typedef struct {
        int          lat;
        int          cyc;
        logic [31:0] data;
    } pulse_t;

    pulse_t      pulses[$];
    pulse_t      confs[$];
    logic [31:0] exp_q[$];
    int          cyc;
    int          errors;
    int          checks;

    data_mem_responder #(.MEM_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .mem_addr(addr), .mem_read_en(re), .mem_write_en(we),
        .mem_write_val(wdata), .mem_read_val(rd_val[1]), .mem_read_valid(rd_valid[1]),
        .mem_busy(busy[1]), .mem_conflict(conflict[1])
    );
    data_mem_responder #(.MEM_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .mem_addr(addr), .mem_read_en(re), .mem_write_en(we),
        .mem_write_val(wdata), .mem_read_val(rd_val[2]), .mem_read_valid(rd_valid[2]),
        .mem_busy(busy[2]), .mem_conflict(conflict[2])
    );
    data_mem_responder #(.MEM_WIDTH(32), .MEM_SIZE(256), .READ_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .mem_addr(addr), .mem_read_en(re), .mem_write_en(we),
        .mem_write_val(wdata), .mem_read_val(rd_val[3]), .mem_read_valid(rd_valid[3]),
        .mem_busy(busy[3]), .mem_conflict(conflict[3])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock; afterwards cyc is the index of the cycle now being observed.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int l = 1; l <= 3; l++) begin
            if (rd_valid[l]) pulses.push_back('{lat: l, cyc: cyc, data: rd_val[l]});
            if (conflict[l]) confs.push_back('{lat: l, cyc: cyc, data: 32'h0});
        end
    endtask

    task automatic req(input logic r, input logic w, input logic [7:0] a, input logic [31:0] d);
        re    = r;
        we    = w;
        addr  = a;
        wdata = d;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    // Steps until busy drops (bounded); optionally pokes addr 9 with read+write mid-clear.
    task automatic wait_clear(input bit poke, output int n);
        n = 0;
        while (busy[1] && n < 300) begin
            if (poke && n >= 100 && n <= 110) req(1'b1, 1'b1, 8'd9, 32'h0000_1234);
            else                              req(1'b0, 1'b0, 8'h00, 32'h0);
            n++;
        end
        re = 1'b0;
        we = 1'b0;
    endtask

    // Compares logged pulses of one instance against exp_q, one per cycle from 'first'.
    task automatic expect_reads(input int lat, input int first, input string tag);
        int n;
        n = 0;
        foreach (pulses[i]) begin
            if (pulses[i].lat == lat) begin
                if (n < exp_q.size()) begin
                    check($sformatf("%s_L%0d_cyc%0d", tag, lat, n), pulses[i].cyc, first + n);
                    check($sformatf("%s_L%0d_data%0d", tag, lat, n), pulses[i].data, exp_q[n]);
                end
                n++;
            end
        end
        check($sformatf("%s_L%0d_count", tag, lat), n, exp_q.size());
    endtask

    task automatic expect_conflict(input int lat, input int at, input string tag);
        int n;
        n = 0;
        foreach (confs[i]) begin
            if (confs[i].lat == lat) begin
                check($sformatf("%s_L%0d_cyc", tag, lat), confs[i].cyc, at);
                n++;
            end
        end
        check($sformatf("%s_L%0d_count", tag, lat), n, 1);
    endtask

    initial begin
        int n;
        int c0;
        int c1;
        errors = 0;
        checks = 0;
        cyc    = 0;
        reset  = 1'b1;
        re     = 1'b0;
        we     = 1'b0;
        addr   = '0;
        wdata  = '0;
        step();
        step();
        reset = 1'b0;

        // Reset state, clear length, and requests ignored while busy.
        check("rst_busy", {29'h0, busy}, 32'h7);
        check("rst_valid", {29'h0, rd_valid}, 32'h0);
        check("rst_conflict", {29'h0, conflict}, 32'h0);
        check("rst_val1", rd_val[1], 32'h0);
        check("rst_val3", rd_val[3], 32'h0);
        pulses.delete();
        confs.delete();
        wait_clear(1'b1, n);
        check("clear_len", n, 256);
        check("clear_busy_low", {29'h0, busy}, 32'h0);
        check("clear_no_valid", pulses.size(), 0);
        check("clear_no_conflict", confs.size(), 0);
        check("clear_val_zero", rd_val[2], 32'h0);

        // Write then read on the next cycle; value holds afterwards.
        pulses.delete();
        req(1'b0, 1'b1, 8'd5, 32'hDEAD_BEEF);
        c0 = cyc;
        req(1'b1, 1'b0, 8'd5, 32'h0);
        idle(6);
        exp_q = {};
        exp_q.push_back(32'hDEAD_BEEF);
        for (int l = 1; l <= 3; l++) begin
            expect_reads(l, c0 + l, "wr_rd");
            check($sformatf("wr_rd_hold_L%0d", l), rd_val[l], 32'hDEAD_BEEF);
        end

        // Back-to-back reads return in order.
        req(1'b0, 1'b1, 8'd1, 32'h11);
        req(1'b0, 1'b1, 8'd2, 32'h22);
        req(1'b0, 1'b1, 8'd3, 32'h33);
        pulses.delete();
        c0 = cyc;
        req(1'b1, 1'b0, 8'd1, 32'h0);
        req(1'b1, 1'b0, 8'd2, 32'h0);
        req(1'b1, 1'b0, 8'd3, 32'h0);
        idle(6);
        exp_q = {};
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h33);
        for (int l = 1; l <= 3; l++) expect_reads(l, c0 + l, "b2b");

        // Read and write together: write lands, read dropped, conflict pulses next cycle.
        pulses.delete();
        confs.delete();
        c0 = cyc;
        req(1'b1, 1'b1, 8'd7, 32'hA5A5_A5A5);
        c1 = cyc;
        req(1'b1, 1'b0, 8'd7, 32'h0);
        idle(6);
        exp_q = {};
        exp_q.push_back(32'hA5A5_A5A5);
        for (int l = 1; l <= 3; l++) begin
            expect_reads(l, c1 + l, "conf_rd");
            expect_conflict(l, c0 + 1, "conf");
        end

        // The write to addr 9 issued during the clear must not have landed.
        pulses.delete();
        c0 = cyc;
        req(1'b1, 1'b0, 8'd9, 32'h0);
        idle(5);
        exp_q = {};
        exp_q.push_back(32'h0);
        for (int l = 1; l <= 3; l++) expect_reads(l, c0 + l, "busy_wr");

        // Reset with a read in flight: deeper pipelines drop it, array is re-cleared.
        req(1'b0, 1'b1, 8'd12, 32'h77);
        pulses.delete();
        c0 = cyc;
        req(1'b1, 1'b0, 8'd12, 32'h0);
        reset = 1'b1;
        req(1'b0, 1'b0, 8'h00, 32'h0);
        reset = 1'b0;
        check("mid_rst_busy", {29'h0, busy}, 32'h7);
        check("mid_rst_valid", {29'h0, rd_valid}, 32'h0);
        check("mid_rst_val2", rd_val[2], 32'h0);
        wait_clear(1'b0, n);
        check("reclear_len", n, 256);
        exp_q = {};
        exp_q.push_back(32'h77);
        expect_reads(1, c0 + 1, "mid_rst");
        exp_q = {};
        expect_reads(2, 0, "mid_rst");
        expect_reads(3, 0, "mid_rst");

        pulses.delete();
        c0 = cyc;
        req(1'b1, 1'b0, 8'd12, 32'h0);
        req(1'b1, 1'b0, 8'd5, 32'h0);
        idle(6);
        exp_q = {};
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int l = 1; l <= 3; l++) expect_reads(l, c0 + l, "post_clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
